// File: rtl/snes_audio_rx.sv
// S-DSP serial audio receiver: oversamples BCK/LRCK/DATA in the mclock domain,
// deserialises left-justified stereo pairs and tracks frame lock and framing faults.
module snes_audio_rx #(
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 16,
    parameter int LOCK_PAIRS  = 2
) (
    input  logic                   mclock,
    input  logic                   reset,
    input  logic                   bclk_in,
    input  logic                   lrck_in,
    input  logic                   sdata_in,
    input  logic                   clr_err,
    output logic [SAMPLE_BITS-1:0] left_out,
    output logic [SAMPLE_BITS-1:0] right_out,
    output logic                   sample_valid,
    output logic                   frame_err,
    output logic                   locked
);

    localparam int          GP_W       = $clog2(LOCK_PAIRS + 1);
    localparam logic [5:0]  CNT_MAX    = 6'd63;
    localparam logic [5:0]  SLOT_CNT   = 6'(SLOT_BITS);
    localparam logic [5:0]  SAMPLE_CNT = 6'(SAMPLE_BITS);
    localparam logic [GP_W-1:0] GP_MAX = GP_W'(LOCK_PAIRS);

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        RX_LEFT  = 2'd1,
        RX_RIGHT = 2'd2
    } state_t;

    // Line order in the sync vectors: [2] sdata, [1] lrck, [0] bclk.
    logic [2:0]             sync1_q, sync1_d;
    logic [2:0]             sync2_q, sync2_d;
    logic                   hist_q, hist_d;
    logic                   prev_lrck_q, prev_lrck_d;
    logic                   have_prev_q, have_prev_d;
    state_t                 state_q, state_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [SAMPLE_BITS-1:0] left_hold_q, left_hold_d;
    logic                   left_good_q, left_good_d;
    logic                   pair_cplt_q, pair_cplt_d;
    logic [GP_W-1:0]        good_pairs_q, good_pairs_d;
    logic [SAMPLE_BITS-1:0] left_out_q, left_out_d;
    logic [SAMPLE_BITS-1:0] right_out_q, right_out_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   locked_q, locked_d;

    logic            rise;
    logic            lr_bit;
    logic            din_bit;
    logic            boundary;
    logic            slot_good;
    logic            fault;
    logic            publish;
    logic [GP_W-1:0] gp_next;

    assign rise      = sync2_q[0] & ~hist_q;
    assign lr_bit    = sync2_q[1];
    assign din_bit   = sync2_q[2];
    // The first rise after reset only seeds prev_lrck, so reset never fakes a boundary.
    assign boundary  = rise & have_prev_q & (lr_bit != prev_lrck_q);
    assign slot_good = (bit_cnt_q == SLOT_CNT);
    assign gp_next   = (good_pairs_q == GP_MAX) ? GP_MAX : good_pairs_q + 1'b1;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        sync1_d      = {sdata_in, lrck_in, bclk_in};
        sync2_d      = sync1_q;
        hist_d       = sync2_q[0];
        prev_lrck_d  = prev_lrck_q;
        have_prev_d  = have_prev_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        left_hold_d  = left_hold_q;
        left_good_d  = left_good_q;
        pair_cplt_d  = pair_cplt_q;
        good_pairs_d = good_pairs_q;
        left_out_d   = left_out_q;
        right_out_d  = right_out_q;
        valid_d      = 1'b0;
        frame_err_d  = clr_err ? 1'b0 : frame_err_q;
        locked_d     = locked_q;
        fault        = 1'b0;
        publish      = 1'b0;

        if (rise) begin
            prev_lrck_d = lr_bit;
            have_prev_d = 1'b1;
            if (boundary) begin
                bit_cnt_d = 6'd1;
                shift_d   = {{(SAMPLE_BITS-1){1'b0}}, din_bit};
            end else begin
                if (bit_cnt_q != CNT_MAX) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
                if (bit_cnt_q < SAMPLE_CNT) begin
                    shift_d = {shift_q[SAMPLE_BITS-2:0], din_bit};
                end
            end
        end

        case (state_q)
            SEARCH: begin
                if (boundary) begin
                    state_d     = lr_bit ? RX_LEFT : RX_RIGHT;
                    pair_cplt_d = lr_bit;
                    left_good_d = 1'b0;
                end
            end
            RX_LEFT: begin
                if (boundary) begin
                    state_d     = RX_RIGHT;
                    left_hold_d = shift_q;
                    left_good_d = slot_good;
                    fault       = ~slot_good;
                end
            end
            RX_RIGHT: begin
                if (boundary) begin
                    state_d     = RX_LEFT;
                    fault       = ~slot_good;
                    publish     = slot_good & pair_cplt_q & left_good_q;
                    pair_cplt_d = 1'b1;
                    left_good_d = 1'b0;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        if (publish) begin
            left_out_d   = left_hold_q;
            right_out_d  = shift_q;
            valid_d      = 1'b1;
            good_pairs_d = gp_next;
            if (gp_next == GP_MAX) begin
                locked_d = 1'b1;
            end
        end

        // A fault outranks a simultaneous clr_err.
        if (fault) begin
            frame_err_d  = 1'b1;
            good_pairs_d = '0;
            locked_d     = 1'b0;
        end
    end

    always_ff @(posedge mclock) begin
        if (!reset) begin
            // NOTE: everything is reset, including the sample registers, since outputs must read 0.
            sync1_q      <= '0;
            sync2_q      <= '0;
            hist_q       <= 1'b0;
            prev_lrck_q  <= 1'b0;
            have_prev_q  <= 1'b0;
            state_q      <= SEARCH;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            left_good_q  <= 1'b0;
            pair_cplt_q  <= 1'b0;
            good_pairs_q <= '0;
            left_out_q   <= '0;
            right_out_q  <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            prev_lrck_q  <= prev_lrck_d;
            have_prev_q  <= have_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            left_good_q  <= left_good_d;
            pair_cplt_q  <= pair_cplt_d;
            good_pairs_q <= good_pairs_d;
            left_out_q   <= left_out_d;
            right_out_q  <= right_out_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            locked_q     <= locked_d;
        end
    end

    assign left_out     = left_out_q;
    assign right_out    = right_out_q;
    assign sample_valid = valid_q;
    assign frame_err    = frame_err_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_snes_audio_rx.sv
// Self-checking bench for snes_audio_rx: table-driven pair stream plus hand-written
// latency, clear/fault, reset and random-phase sequences, with a strobe scoreboard.
module tb_snes_audio_rx;

    logic mclock = 1'b0;
    logic reset, bclk_in, lrck_in, sdata_in, clr_err;
    logic [15:0] left16, right16, left24, right24;
    logic sv16, fe16, lk16, sv24, fe24, lk24;

    snes_audio_rx #(.SAMPLE_BITS(16), .SLOT_BITS(16), .LOCK_PAIRS(2)) dut16 (
        .mclock(mclock), .reset(reset), .bclk_in(bclk_in), .lrck_in(lrck_in),
        .sdata_in(sdata_in), .clr_err(clr_err), .left_out(left16), .right_out(right16),
        .sample_valid(sv16), .frame_err(fe16), .locked(lk16)
    );

    snes_audio_rx #(.SAMPLE_BITS(16), .SLOT_BITS(24), .LOCK_PAIRS(2)) dut24 (
        .mclock(mclock), .reset(reset), .bclk_in(bclk_in), .lrck_in(lrck_in),
        .sdata_in(sdata_in), .clr_err(clr_err), .left_out(left24), .right_out(right24),
        .sample_valid(sv24), .frame_err(fe24), .locked(lk24)
    );

    always #5 mclock = ~mclock;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          lbits;
        int          rbits;
        logic        pub;
        logic        err_after;
        logic        lock_after;
    } vec_t;

    pair_t q16[$];
    pair_t q24[$];
    vec_t  tbl[7];
    int    n_checks = 0;
    int    n_fail = 0;
    logic [15:0] last_l = 16'h0;
    logic [15:0] last_r = 16'h0;
    logic  prev_sv16 = 1'b0;
    logic  prev_sv24 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected pair.
    always @(negedge mclock) begin
        if (sv16) begin
            check("sv16_single_cycle", 32'(prev_sv16), 32'd0);
            if (q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe16: got left=%h right=%h expected no strobe", left16, right16);
            end else begin
                check("sb16_left", 32'(left16), 32'(q16[0].l));
                check("sb16_right", 32'(right16), 32'(q16[0].r));
                void'(q16.pop_front());
            end
        end
        if (sv24) begin
            check("sv24_single_cycle", 32'(prev_sv24), 32'd0);
            if (q24.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe24: got left=%h right=%h expected no strobe", left24, right24);
            end else begin
                check("sb24_left", 32'(left24), 32'(q24[0].l));
                check("sb24_right", 32'(right24), 32'(q24[0].r));
                void'(q24.pop_front());
            end
        end
        prev_sv16 <= sv16;
        prev_sv24 <= sv24;
    end

    function automatic logic slot_bit(input logic [15:0] w, input int i);
        if (i < 16) return w[15-i];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive_bit(input logic lr, input logic d, input int lo, input int hi);
        bclk_in  = 1'b0;
        lrck_in  = lr;
        sdata_in = d;
        #(lo);
        bclk_in  = 1'b1;
        #(hi);
    endtask

    task automatic send_slot(input logic lr, input logic [15:0] w, input int first,
                             input int nbits, input int lo, input int hi);
        for (int i = first; i < nbits; i++) drive_bit(lr, slot_bit(w, i), lo, hi);
    endtask

    task automatic do_reset();
        @(posedge mclock);
        #1;
        reset    = 1'b0;
        bclk_in  = 1'b0;
        lrck_in  = 1'b0;
        sdata_in = 1'b0;
        clr_err  = 1'b0;
        repeat (2) @(posedge mclock);
        #1 reset = 1'b1;
    endtask

    task automatic check_after(input vec_t v, input int idx);
        check($sformatf("tbl%0d_frame_err", idx), 32'(fe16), 32'(v.err_after));
        check($sformatf("tbl%0d_locked", idx), 32'(lk16), 32'(v.lock_after));
        check($sformatf("tbl%0d_left_out", idx), 32'(left16), 32'(last_l));
        check($sformatf("tbl%0d_right_out", idx), 32'(right16), 32'(last_r));
    endtask

    initial begin
        logic [15:0] rl, rr;
        int extra;
        longint now;

        reset = 1'b0; bclk_in = 1'b0; lrck_in = 1'b0; sdata_in = 1'b0; clr_err = 1'b0;
        //             left      right     lbits rbits pub   err   lock (after pair closes)
        tbl[0] = '{16'hA5C3, 16'h3C5A, 16, 16, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{16'h8001, 16'h7FFE, 16, 16, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'h1111, 16'h2222, 15, 16, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'hCAFE, 16'hBEEF, 16, 16, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{16'h0F0F, 16'hF0F0, 16, 17, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{16'hFFFF, 16'h0000, 16, 16, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{16'h0001, 16'h8000, 16, 16, 1'b1, 1'b1, 1'b1};

        repeat (3) @(posedge mclock);
        #1;
        check("rst_left", 32'(left16), 32'd0);
        check("rst_right", 32'(right16), 32'd0);
        check("rst_valid", 32'(sv16), 32'd0);
        check("rst_frame_err", 32'(fe16), 32'd0);
        check("rst_locked", 32'(lk16), 32'd0);

        // Table stream, entered mid-right slot: the partial preamble must stay silent.
        do_reset();
        send_slot(1'b0, 16'h5A5A, 9, 16, 40, 40);
        for (int k = 0; k < 7; k++) begin
            drive_bit(1'b1, tbl[k].l[15], 40, 40);
            if (k > 0) check_after(tbl[k-1], k - 1);
            send_slot(1'b1, tbl[k].l, 1, tbl[k].lbits, 40, 40);
            send_slot(1'b0, tbl[k].r, 0, tbl[k].rbits, 40, 40);
            if (tbl[k].pub) begin
                q16.push_back('{tbl[k].l, tbl[k].r});
                last_l = tbl[k].l;
                last_r = tbl[k].r;
            end
        end
        drive_bit(1'b1, 1'b0, 40, 40);
        check_after(tbl[6], 6);

        // clr_err clears the sticky flag; lock is unaffected.
        clr_err = 1'b1;
        @(posedge mclock);
        #1 clr_err = 1'b0;
        check("clr_err_clears", 32'(fe16), 32'd0);
        check("clr_keeps_lock", 32'(lk16), 32'd1);

        // Short (14-bit) left slot whose fault lands on the same edge as clr_err.
        send_slot(1'b1, 16'h0000, 1, 14, 40, 40);
        bclk_in = 1'b0; lrck_in = 1'b0; sdata_in = 1'b1;
        #40;
        bclk_in = 1'b1;
        clr_err = 1'b1;
        repeat (3) @(posedge mclock);
        #1 clr_err = 1'b0;
        check("fault_beats_clr", 32'(fe16), 32'd1);
        check("fault_drops_lock", 32'(lk16), 32'd0);
        #10;

        // Latency: strobe appears exactly at edge N+2 of the boundary rise.
        do_reset();
        send_slot(1'b0, 16'h0000, 11, 16, 40, 40);
        send_slot(1'b1, 16'h1234, 0, 16, 40, 40);
        send_slot(1'b0, 16'h5678, 0, 16, 40, 40);
        q16.push_back('{16'h1234, 16'h5678});
        bclk_in = 1'b0; lrck_in = 1'b1; sdata_in = 1'b0;
        #40;
        bclk_in = 1'b1;
        @(posedge mclock);
        #1 check("lat_edge_n", 32'(sv16), 32'd0);
        @(posedge mclock);
        #1 check("lat_edge_n1", 32'(sv16), 32'd0);
        @(posedge mclock);
        #1 check("lat_edge_n2", 32'(sv16), 32'd1);
        check("lat_left", 32'(left16), 32'h1234);
        check("lat_locked_one_pair", 32'(lk16), 32'd0);
        #10;

        // One-cycle reset mid-left slot, then resynchronise.
        send_slot(1'b1, 16'hFFFF, 1, 8, 40, 40);
        bclk_in = 1'b0;
        reset = 1'b0;
        @(posedge mclock);
        #1 reset = 1'b1;
        check("midrst_left", 32'(left16), 32'd0);
        check("midrst_right", 32'(right16), 32'd0);
        check("midrst_valid", 32'(sv16), 32'd0);
        check("midrst_locked", 32'(lk16), 32'd0);
        send_slot(1'b1, 16'hFFFF, 8, 16, 40, 40);
        send_slot(1'b0, 16'h0F0F, 0, 16, 40, 40);
        send_slot(1'b1, 16'h9ABC, 0, 16, 40, 40);
        send_slot(1'b0, 16'hDEF0, 0, 16, 40, 40);
        q16.push_back('{16'h9ABC, 16'hDEF0});
        drive_bit(1'b1, 1'b0, 40, 40);
        check("midrst_no_err", 32'(fe16), 32'd0);
        check("midrst_pair_left", 32'(left16), 32'h9ABC);

        // 24-bit slots: 16 data bits, 8 junk bits ignored.
        do_reset();
        send_slot(1'b0, 16'h0000, 11, 16, 40, 40);
        send_slot(1'b1, 16'h1234, 0, 24, 40, 40);
        send_slot(1'b0, 16'hABCD, 0, 24, 40, 40);
        q24.push_back('{16'h1234, 16'hABCD});
        send_slot(1'b1, 16'h5555, 0, 24, 40, 40);
        send_slot(1'b0, 16'hAAAA, 0, 24, 40, 40);
        q24.push_back('{16'h5555, 16'hAAAA});
        drive_bit(1'b1, 1'b0, 40, 40);
        check("s24_no_err", 32'(fe24), 32'd0);
        check("s24_locked", 32'(lk24), 32'd1);
        check("s24_left", 32'(left24), 32'h5555);
        check("s24_right", 32'(right24), 32'hAAAA);

        // Minimum 3-mclock half periods with a random phase per pair.
        do_reset();
        send_slot(1'b0, 16'h0000, 12, 16, 30, 30);
        for (int p = 0; p <= 100; p++) begin
            rl = 16'($urandom);
            rr = 16'($urandom);
            extra = $urandom_range(0, 9);
            now = longint'($time);
            if (((now + 30 + extra) % 10) == 5) extra = extra + 1;
            drive_bit(1'b1, rl[15], 30 + extra, 30);
            if (p < 100) begin
                send_slot(1'b1, rl, 1, 16, 30, 30);
                send_slot(1'b0, rr, 0, 16, 30, 30);
                q16.push_back('{rl, rr});
            end
        end
        repeat (10) @(posedge mclock);
        #1;
        check("rand_no_err", 32'(fe16), 32'd0);
        check("rand_locked", 32'(lk16), 32'd1);
        check("sb16_drained", 32'(q16.size()), 32'd0);
        check("sb24_drained", 32'(q24.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/snes_audio_rx.md
Name: snes_audio_rx

Overview:
- Receiver for the S-DSP serial audio stream (BCK/LRCK/DATA), the stream the DAC clock path drives.
- Oversamples the three asynchronous lines in the mclock domain and deserialises them MSB-first into 16-bit left/right sample pairs.
- Publishes each complete stereo pair with a one-cycle valid strobe, tracks frame lock and flags framing faults for the SNES_TST capture/compare logic.

Parameters:
SAMPLE_BITS, 16, data bits captured per channel slot (MSB first)
SLOT_BITS, 16, exact BCK rising edges per channel slot; must be >= SAMPLE_BITS, max 63
LOCK_PAIRS, 2, consecutive good pairs required before locked asserts

Ports:
mclock  in  1  master clock, sole clock, all logic on posedge
reset  in  1  synchronous, active-low; 0 = reset
bclk_in  in  1  serial bit clock, asynchronous to mclock
lrck_in  in  1  word select, asynchronous; 1 = left slot, 0 = right slot
sdata_in  in  1  serial data, asynchronous
clr_err  in  1  synchronous clear of frame_err
left_out  out  SAMPLE_BITS  last published left sample
right_out  out  SAMPLE_BITS  last published right sample
sample_valid  out  1  one-mclock pulse: left_out/right_out updated
frame_err  out  1  sticky framing-fault flag
locked  out  1  LOCK_PAIRS consecutive good pairs received, no fault since

Behaviour:
- Reset (reset=0 at a posedge): left_out=0, right_out=0, sample_valid=0, frame_err=0, locked=0, state=SEARCH, bit counter=0, shift regs=0, sync flops=0.
- Input sync: each input passes through 2 flops, then one history flop on bclk. A rise is detected when sync2=1 and hist=0. Requirement: bclk high and low each >= 3 mclock periods; slower streams are legal.
- On a detected rise, sample sync2 of lrck and sdata (same-delay path). A slot boundary occurs when sampled lrck != lrck sampled at the previous rise.
- Format: left-justified. The bit at the boundary rise is the MSB of the new slot.
  - The first SAMPLE_BITS bits shift in MSB-first.
  - Further bits up to SLOT_BITS are counted and ignored.
  - The counter saturates at 63.
- Slot check at each boundary: the closing slot is good iff count == SLOT_BITS.
- States:
  - SEARCH: ignores data until the first boundary, then enters RX_LEFT (lrck=1) or RX_RIGHT (lrck=0). The pair in progress is marked incomplete. No error is raised for this partial slot.
  - RX_LEFT to RX_RIGHT (boundary, lrck 1->0): latch the left shift reg into left_hold; record the left-slot good bit.
  - RX_RIGHT to RX_LEFT (boundary, lrck 0->1): if pair complete and both slots good, then left_out=left_hold, right_out=right shift reg, sample_valid=1 for exactly one cycle.
  - Any bad slot in RX_LEFT/RX_RIGHT: set frame_err, clear the good-pair counter, drop locked, discard the pair (no strobe, outputs hold).
  - The new slot then starts normally; the next pair is complete again.
- Latency: N = first mclock edge sampling bclk_in=1 at the boundary rise. Shift/count/state update and sample_valid/left_out/right_out all change at edge N+2.
- locked asserts at the same edge as the LOCK_PAIRS-th consecutive strobe. It deasserts at the edge a fault is detected.
- frame_err: sticky. clr_err=1 clears it at the next edge. A fault detected in the same cycle as clr_err wins, so frame_err=1.
- If lrck_in never toggles, the counter saturates at 63 and no strobe is produced. The fault is reported at the next boundary.
- Outputs hold between strobes. sample_valid is never asserted in two consecutive cycles.
- reset low mid-slot: immediate full reset. The in-flight pair is lost; the receiver restarts in SEARCH.

Test Plan:
- Nominal stream, bclk = mclock/8, two pairs L=16'hA5C3 R=16'h3C5A then L=16'h8001 R=16'h7FFE -> second boundary-to-left produces sample_valid, left_out=16'hA5C3, right_out=16'h3C5A, exactly 2 mclocks after the boundary rise; locked=1 after 2nd good pair.
- Start mid-right slot after reset -> first partial pair yields no strobe and no frame_err; the following full pair is published.
- Short left slot (15 bits) -> frame_err=1, locked=0, pair dropped, outputs unchanged; next good pair strobes; clr_err clears the flag; fault coincident with clr_err leaves frame_err=1.
- SLOT_BITS=24, SAMPLE_BITS=16, data 16'h1234 followed by 8 junk bits -> left_out=16'h1234, junk ignored, no error.
- Boundary timing: bclk high/low = 3 mclocks with random phase of all inputs vs mclock -> all 100 pairs match reference model, sample_valid never stretched.
- reset=0 for one cycle mid-left slot -> all outputs 0 next edge, SEARCH re-entered, first complete pair after reset published correctly.
